// File: rtl/data_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared constants and types for the data-memory responder and its UART.
//   IO_SEL_BIT      : address bit that selects the IO page instead of RAM
//   *_OFF           : word offsets of the IO registers (ramAddr[7:2])
//   STATUS_*_BIT    : bit positions inside the UART_STATUS register
//   uartState_e     : UART transmitter state encoding
// ---------------------------------------------------------------------------
package data_mem_responder_pkg;

  localparam int IO_SEL_BIT = 22;

  localparam logic [5:0] LEDS_OFF        = 6'd0;
  localparam logic [5:0] UART_DATA_OFF   = 6'd1;
  localparam logic [5:0] UART_STATUS_OFF = 6'd2;
  localparam logic [5:0] TIMER_OFF       = 6'd3;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_OVF_BIT  = 1;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uartState_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
// Processor data-port bus between the core (master) and the memory-side
// responder (slave).
//   ramAddr  : byte address of the access
//   ramRStrb : single-cycle read request
//   memWData : lane-aligned write data
//   memWMask : byte write enables, nonzero means a write
//   ramRData : registered read data returned by the responder
// ---------------------------------------------------------------------------
interface data_mem_responder_if;

  logic [31:0] ramAddr;
  logic        ramRStrb;
  logic [31:0] memWData;
  logic [3:0]  memWMask;
  logic [31:0] ramRData;

  modport master (
    output ramAddr,
    output ramRStrb,
    output memWData,
    output memWMask,
    input  ramRData
  );

  modport slave (
    input  ramAddr,
    input  ramRStrb,
    input  memWData,
    input  memWMask,
    output ramRData
  );

endinterface

// File: rtl/data_mem_responder_uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// 8N1 serial transmitter, LSB first, every bit held DIV clock cycles.
//   clk   : system clock
//   reset : synchronous active-high reset, aborts any frame in flight
//   start : pulse while idle to launch a frame with 'data'
//   data  : byte to send, captured on the start cycle
//   tx    : serial line, idle high
//   busy  : high from the cycle after start until the stop bit has ended
// ---------------------------------------------------------------------------
module uart_tx
  import data_mem_responder_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  uartState_e    state_q, state_d;
  logic [CW-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          bitEnd;

  assign bitEnd = (baudCnt_q == CNT_LAST);

  // State register; reset drops straight back to idle so a partial frame
  // never resumes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= UART_IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state and line output. The baud counter restarts at every bit
  // boundary; the shift register moves right so bit 0 is always on the line.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    tx        = 1'b1;
    busy      = 1'b1;
    unique case (state_q)
      UART_IDLE: begin
        busy      = 1'b0;
        baudCnt_d = '0;
        if (start) begin
          shift_d  = data;
          bitIdx_d = '0;
          state_d  = UART_START;
        end
      end
      UART_START: begin
        tx = 1'b0;
        if (bitEnd) begin
          baudCnt_d = '0;
          state_d   = UART_DATA;
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
      UART_DATA: begin
        tx = shift_q[0];
        if (bitEnd) begin
          baudCnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
      UART_STOP: begin
        tx = 1'b1;
        if (bitEnd) begin
          baudCnt_d = '0;
          state_d   = UART_IDLE;
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
      default: begin
        state_d = UART_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the processor data port: data RAM plus a small
// IO page (LED register, UART transmitter, free-running cycle timer).
//   clk    : system clock
//   reset  : synchronous active-high reset, wins over any request
//   bus    : data-port slave (ramAddr, ramRStrb, memWData, memWMask in;
//            ramRData out, registered, one cycle after the strobe)
//   leds   : LED register
//   uartTx : serial output, idle high
// Address bit 22 picks IO over RAM. RAM aliases above its size; IO decodes
// only the word offset ramAddr[7:2].
// ---------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int RAM_WORDS   = 16384,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int LED_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 uartTx
);

  localparam int AW  = $clog2(RAM_WORDS);
  localparam int DIV = CLK_FREQ_HZ / BAUD;

  logic [31:0]          mem [RAM_WORDS];
  logic [31:0]          ramRData_q;
  logic [LED_WIDTH-1:0] leds_q;
  logic [31:0]          timer_q;
  logic                 overflow_q, overflow_d;

  logic          isIo;
  logic [5:0]    ioOff;
  logic [AW-1:0] wordIdx;
  logic          isWrite;
  logic          ramWrEn;
  logic          ledWrEn;
  logic [31:0]   ledsMerged;
  logic          uartWrite;
  logic          uartStart;
  logic          uartDrop;
  logic          statusClear;
  logic          uartBusy;
  logic [31:0]   ioRdData;
  logic          unusedBits;

  assign isIo    = bus.ramAddr[IO_SEL_BIT];
  assign ioOff   = bus.ramAddr[7:2];
  assign wordIdx = bus.ramAddr[AW+1:2];
  assign isWrite = |bus.memWMask;

  assign ramWrEn     = isWrite && !isIo && !reset;
  assign ledWrEn     = isWrite && isIo && (ioOff == LEDS_OFF);
  assign uartWrite   = isIo && (ioOff == UART_DATA_OFF) && bus.memWMask[0];
  assign uartStart   = uartWrite && !uartBusy;
  assign uartDrop    = uartWrite && uartBusy;
  assign statusClear = isIo && (ioOff == UART_STATUS_OFF) && bus.memWMask[0]
                       && bus.memWData[STATUS_OVF_BIT];

  // Address bits above the RAM index and the LED truncation are deliberately
  // ignored; folding them here keeps that explicit.
  assign unusedBits = ^{bus.ramAddr, ledsMerged};

  // RAM byte-lane writes. Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (ramWrEn) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.memWMask[b]) begin
          mem[wordIdx][8*b +: 8] <= bus.memWData[8*b +: 8];
        end
      end
    end
  end

  // IO read mux, evaluated from the registers as they stand in the strobe
  // cycle.
  always_comb begin
    ioRdData = '0;
    unique case (ioOff)
      LEDS_OFF:        ioRdData = 32'(leds_q);
      UART_STATUS_OFF: begin
        ioRdData[STATUS_BUSY_BIT] = uartBusy;
        ioRdData[STATUS_OVF_BIT]  = overflow_q;
      end
      TIMER_OFF:       ioRdData = timer_q;
      default:         ioRdData = '0;
    endcase
  end

  // Read data register. The RAM read uses the pre-edge contents, so a read
  // and write to the same word return the old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      ramRData_q <= '0;
    end else if (bus.ramRStrb) begin
      ramRData_q <= isIo ? ioRdData : mem[wordIdx];
    end
  end

  // Byte-masked merge into the zero-extended LED value, truncated on store.
  always_comb begin
    ledsMerged = 32'(leds_q);
    for (int b = 0; b < 4; b++) begin
      if (bus.memWMask[b]) begin
        ledsMerged[8*b +: 8] = bus.memWData[8*b +: 8];
      end
    end
  end

  // LED register.
  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q <= '0;
    end else if (ledWrEn) begin
      leds_q <= ledsMerged[LED_WIDTH-1:0];
    end
  end

  // Overflow flag; the set is applied after the clear so a dropped byte in
  // the same cycle as a clear leaves the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (statusClear) begin
      overflow_d = 1'b0;
    end
    if (uartDrop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  // Free-running cycle timer, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  uart_tx #(
    .DIV (DIV)
  ) u_uart_tx (
    .clk   (clk),
    .reset (reset),
    .start (uartStart),
    .data  (bus.memWData[7:0]),
    .tx    (uartTx),
    .busy  (uartBusy)
  );

  assign bus.ramRData = ramRData_q;
  assign leds         = leds_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Directed self-checking bench for data_mem_responder with a small RAM and
// a 4-cycle UART bit time.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int RAM_WORDS   = 256;
  localparam int CLK_FREQ_HZ = 400;
  localparam int BAUD        = 100;
  localparam int LED_WIDTH   = 8;

  localparam logic [31:0] A_LEDS   = 32'h0040_0000;
  localparam logic [31:0] A_UDATA  = 32'h0040_0004;
  localparam logic [31:0] A_STATUS = 32'h0040_0008;
  localparam logic [31:0] A_TIMER  = 32'h0040_000C;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [LED_WIDTH-1:0] leds;
  logic                 uartTx;

  int checks = 0;
  int passes = 0;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .RAM_WORDS   (RAM_WORDS),
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD        (BAUD),
    .LED_WIDTH   (LED_WIDTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .leds   (leds),
    .uartTx (uartTx)
  );

  always #5 clk = ~clk;

  // One bus cycle: drive on the falling edge, let the rising edge take it,
  // then return the bus to idle just after that edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic rd,
                               input logic [31:0] wdata, input logic [3:0] mask);
    @(negedge clk);
    bus.ramAddr  = addr;
    bus.ramRStrb = rd;
    bus.memWData = wdata;
    bus.memWMask = mask;
    @(posedge clk);
    #1;
    bus.ramRStrb = 1'b0;
    bus.memWMask = 4'b0000;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.ramAddr  = '0;
    bus.ramRStrb = 1'b0;
    bus.memWData = '0;
    bus.memWMask = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ramRData !== 32'h0) $display("[TB] FAIL reset_rdata got %h want %h", bus.ramRData, 32'h0); else passes++;
    checks++; if (leds !== 8'h00) $display("[TB] FAIL reset_leds got %h want %h", leds, 8'h00); else passes++;
    checks++; if (uartTx !== 1'b1) $display("[TB] FAIL reset_tx got %b want 1", uartTx); else passes++;
    @(negedge clk);
    reset        = 1'b0;
    bus.ramAddr  = A_TIMER;
    bus.ramRStrb = 1'b1;
    @(posedge clk);
    #1;
    bus.ramRStrb = 1'b0;
    checks++; if (bus.ramRData !== 32'h0) $display("[TB] FAIL reset_timer got %h want %h", bus.ramRData, 32'h0); else passes++;
    applyStimulus(A_STATUS, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h0) $display("[TB] FAIL reset_status got %h want %h", bus.ramRData, 32'h0); else passes++;
  endtask

  task automatic test_ram();
    logic [31:0] pre;
    applyStimulus(32'h100, 1'b0, 32'hDEADBEEF, 4'b1111);
    applyStimulus(32'h100, 1'b0, 32'h00005500, 4'b0010);
    @(negedge clk);
    bus.ramAddr  = 32'h100;
    bus.ramRStrb = 1'b1;
    #1;
    pre = bus.ramRData;
    checks++; if (pre !== 32'h0) $display("[TB] FAIL ram_no_early_data got %h want %h", pre, 32'h0); else passes++;
    @(posedge clk);
    #1;
    bus.ramRStrb = 1'b0;
    checks++; if (bus.ramRData !== 32'hDEAD55EF) $display("[TB] FAIL ram_masked_read got %h want %h", bus.ramRData, 32'hDEAD55EF); else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ramRData !== 32'hDEAD55EF) $display("[TB] FAIL ram_hold got %h want %h", bus.ramRData, 32'hDEAD55EF); else passes++;
    applyStimulus(32'h100, 1'b1, 32'h11111111, 4'b1111);
    checks++; if (bus.ramRData !== 32'hDEAD55EF) $display("[TB] FAIL ram_read_during_write got %h want %h", bus.ramRData, 32'hDEAD55EF); else passes++;
    applyStimulus(32'h100, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h11111111) $display("[TB] FAIL ram_after_write got %h want %h", bus.ramRData, 32'h11111111); else passes++;
    applyStimulus(32'h104, 1'b0, 32'h12345678, 4'b1111);
    applyStimulus(32'h504, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h12345678) $display("[TB] FAIL ram_alias got %h want %h", bus.ramRData, 32'h12345678); else passes++;
  endtask

  task automatic test_leds();
    applyStimulus(A_LEDS, 1'b0, 32'h000000A5, 4'b1111);
    checks++; if (leds !== 8'hA5) $display("[TB] FAIL leds_write got %h want %h", leds, 8'hA5); else passes++;
    applyStimulus(A_LEDS, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h000000A5) $display("[TB] FAIL leds_read got %h want %h", bus.ramRData, 32'h000000A5); else passes++;
    applyStimulus(A_LEDS, 1'b0, 32'h0000FF3C, 4'b0010);
    checks++; if (leds !== 8'hA5) $display("[TB] FAIL leds_upper_lane got %h want %h", leds, 8'hA5); else passes++;
    applyStimulus(A_LEDS, 1'b0, 32'h0000FF3C, 4'b0001);
    checks++; if (leds !== 8'h3C) $display("[TB] FAIL leds_lane0 got %h want %h", leds, 8'h3C); else passes++;
    applyStimulus(32'h0040_0040, 1'b0, 32'hFFFFFFFF, 4'b1111);
    applyStimulus(32'h0040_0040, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h0) $display("[TB] FAIL unmapped_read got %h want %h", bus.ramRData, 32'h0); else passes++;
    checks++; if (leds !== 8'h3C) $display("[TB] FAIL unmapped_write got %h want %h", leds, 8'h3C); else passes++;
  endtask

  task automatic test_uart();
    logic [7:0] b;
    logic       expBit;
    logic       bitBad;
    b = 8'h53;
    applyStimulus(A_UDATA, 1'b0, {24'h0, b}, 4'b0001);
    bitBad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k < 4) expBit = 1'b0;
      else if (k >= 36) expBit = 1'b1;
      else expBit = b[k/4 - 1];
      if (uartTx !== expBit) bitBad = 1'b1;
      if (k % 4 == 3) begin
        checks++;
        if (bitBad) $display("[TB] FAIL uart_bit%0d got %b want %b", k/4, uartTx, expBit); else passes++;
        bitBad = 1'b0;
      end
    end
    applyStimulus(A_STATUS, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h1) $display("[TB] FAIL uart_busy_last_stop got %h want %h", bus.ramRData, 32'h1); else passes++;
    applyStimulus(A_STATUS, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h0) $display("[TB] FAIL uart_idle_after got %h want %h", bus.ramRData, 32'h0); else passes++;
    applyStimulus(A_UDATA, 1'b0, 32'h000000C4, 4'b0001);
    applyStimulus(A_STATUS, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h1) $display("[TB] FAIL uart_busy_mid got %h want %h", bus.ramRData, 32'h1); else passes++;
    applyStimulus(A_UDATA, 1'b0, 32'h00000077, 4'b0001);
    applyStimulus(A_STATUS, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h3) $display("[TB] FAIL uart_overflow got %h want %h", bus.ramRData, 32'h3); else passes++;
    applyStimulus(A_STATUS, 1'b0, 32'h00000002, 4'b0001);
    applyStimulus(A_STATUS, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h1) $display("[TB] FAIL uart_overflow_clear got %h want %h", bus.ramRData, 32'h1); else passes++;
    repeat (40) @(posedge clk);
    applyStimulus(A_STATUS, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h0) $display("[TB] FAIL uart_drop_not_sent got %h want %h", bus.ramRData, 32'h0); else passes++;
  endtask

  task automatic test_timer();
    logic [31:0] t1;
    logic [31:0] diff;
    applyStimulus(A_TIMER, 1'b1, 32'h0, 4'b0000);
    t1 = bus.ramRData;
    repeat (9) @(posedge clk);
    applyStimulus(A_TIMER, 1'b1, 32'h0, 4'b0000);
    diff = bus.ramRData - t1;
    checks++; if (diff !== 32'd10) $display("[TB] FAIL timer_delta got %0d want %0d", diff, 10); else passes++;
    applyStimulus(A_TIMER, 1'b0, 32'hFFFFFFFF, 4'b1111);
    @(negedge clk);
    force dut.timer_q = 32'hFFFFFFFD;
    #1;
    release dut.timer_q;
    bus.ramAddr  = A_TIMER;
    bus.ramRStrb = 1'b1;
    @(posedge clk);
    #1;
    bus.ramRStrb = 1'b0;
    checks++; if (bus.ramRData !== 32'hFFFFFFFD) $display("[TB] FAIL timer_forced got %h want %h", bus.ramRData, 32'hFFFFFFFD); else passes++;
    applyStimulus(A_TIMER, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'hFFFFFFFE) $display("[TB] FAIL timer_fffe got %h want %h", bus.ramRData, 32'hFFFFFFFE); else passes++;
    applyStimulus(A_TIMER, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'hFFFFFFFF) $display("[TB] FAIL timer_ffff got %h want %h", bus.ramRData, 32'hFFFFFFFF); else passes++;
    applyStimulus(A_TIMER, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h0) $display("[TB] FAIL timer_wrap got %h want %h", bus.ramRData, 32'h0); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    logic       expBit;
    logic       bitBad;
    logic       txBad;
    applyStimulus(A_LEDS, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h3C) $display("[TB] FAIL rst_pre_rdata got %h want %h", bus.ramRData, 32'h3C); else passes++;
    b = 8'hB6;
    applyStimulus(A_UDATA, 1'b0, {24'h0, b}, 4'b0001);
    repeat (17) @(posedge clk);
    #1;
    checks++; if (uartTx !== b[3]) $display("[TB] FAIL rst_in_bit3 got %b want %b", uartTx, b[3]); else passes++;
    @(negedge clk);
    reset        = 1'b1;
    bus.ramAddr  = A_LEDS;
    bus.memWData = 32'hFFFFFFFF;
    bus.memWMask = 4'b1111;
    bus.ramRStrb = 1'b1;
    @(posedge clk);
    #1;
    bus.memWMask = 4'b0000;
    bus.ramRStrb = 1'b0;
    checks++; if (uartTx !== 1'b1) $display("[TB] FAIL rst_mid_tx got %b want 1", uartTx); else passes++;
    checks++; if (leds !== 8'h00) $display("[TB] FAIL rst_mid_leds got %h want %h", leds, 8'h00); else passes++;
    checks++; if (bus.ramRData !== 32'h0) $display("[TB] FAIL rst_mid_rdata got %h want %h", bus.ramRData, 32'h0); else passes++;
    @(negedge clk);
    reset = 1'b0;
    txBad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (uartTx !== 1'b1) txBad = 1'b1;
    end
    checks++; if (txBad) $display("[TB] FAIL rst_no_resume got %b want 1", txBad); else passes++;
    applyStimulus(A_STATUS, 1'b1, 32'h0, 4'b0000);
    checks++; if (bus.ramRData !== 32'h0) $display("[TB] FAIL rst_busy_clear got %h want %h", bus.ramRData, 32'h0); else passes++;
    b = 8'h3A;
    applyStimulus(A_UDATA, 1'b0, {24'h0, b}, 4'b0001);
    bitBad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k < 4) expBit = 1'b0;
      else if (k >= 36) expBit = 1'b1;
      else expBit = b[k/4 - 1];
      if (uartTx !== expBit) bitBad = 1'b1;
      if (k % 4 == 3) begin
        checks++;
        if (bitBad) $display("[TB] FAIL rst_frame_bit%0d got %b want %b", k/4, uartTx, expBit); else passes++;
        bitBad = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_leds();
    test_uart();
    test_timer();
    test_reset_mid_frame();
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
